// File: rtl/graphite_mem_pkg.sv
// Shared types for the async_sdram_ctrl command/response FIFO protocol.
package graphite_mem_pkg;

  localparam int unsigned CMD_WIDTH      = 41;
  localparam int unsigned RSP_WIDTH      = 16;
  localparam int unsigned CMD_ADDR_WIDTH = 24;

  typedef struct packed {
    logic                      we;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [RSP_WIDTH-1:0]      data;
  } mem_cmd_t;

  typedef enum logic [1:0] {IDLE, LATCH, RD_WAIT, RESP} rsp_state_t;

  // An address is backed by RAM only when every bit above the RAM index is zero.
  function automatic logic addr_in_range(input logic [CMD_ADDR_WIDTH-1:0] addr,
                                         input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port RAM, synchronous read, write-first; read data holds while en_i is low.
module mem_sp_ram #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage and registered read port; a write returns the new word on the same access.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q       <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_mem_responder.sv
// Responder end of the command/response FIFO protocol backed by on-chip RAM.
module fifo_mem_responder
  import graphite_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter int unsigned READ_LATENCY   = 2,
  parameter logic [15:0] ERR_WORD       = 16'hDEAD
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  input  logic [CMD_WIDTH-1:0] cmd_d_i,
  input  logic                 cmd_empty_i,
  output logic                 cmd_deq_o,
  output logic [RSP_WIDTH-1:0] rsp_q_o,
  input  logic                 rsp_full_i,
  output logic                 rsp_enq_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [15:0]          wr_count_o,
  output logic [15:0]          rd_count_o
);

  localparam int unsigned LatW = 3;

  rsp_state_t           state_q, state_d;
  logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
  logic                 rd_oor_q, rd_oor_d;
  logic [RSP_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d;
  logic [15:0]          rd_cnt_q, rd_cnt_d;

  mem_cmd_t             cmd_in;
  logic                 cmd_in_range;
  logic                 ram_en, ram_we;
  logic [RSP_WIDTH-1:0] ram_rdata;

  assign cmd_in       = cmd_d_i;
  assign cmd_in_range = addr_in_range(cmd_in.addr, MEM_ADDR_WIDTH);

  mem_sp_ram #(
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH (RSP_WIDTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (cmd_in.addr[MEM_ADDR_WIDTH-1:0]),
    .wdata_i (cmd_in.data),
    .rdata_o (ram_rdata)
  );

  // Next-state, strobes and RAM access; only one command is ever in flight.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rd_oor_d   = rd_oor_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    cmd_deq_o  = 1'b0;
    rsp_enq_o  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_deq_o = !cmd_empty_i;
        if (cmd_deq_o) state_d = LATCH;
      end
      LATCH: begin
        // The RAM sees the command directly, so the read is issued in this cycle.
        ram_en = 1'b1;
        if (cmd_in.we) begin
          ram_we = cmd_in_range;
          if (cmd_in_range) wr_cnt_d = wr_cnt_q + 16'd1;
          else              err_d    = 1'b1;
          state_d = IDLE;
        end else begin
          rd_oor_d  = !cmd_in_range;
          if (!cmd_in_range) err_d = 1'b1;
          lat_cnt_d = LatW'(READ_LATENCY - 1);
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_data_d = rd_oor_q ? ERR_WORD : ram_rdata;
          state_d    = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LatW'(1);
        end
      end
      RESP: begin
        rsp_enq_o = !rsp_full_i;
        if (rsp_enq_o) begin
          rd_cnt_d = rd_cnt_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset edge must not see a dequeue, enqueue or RAM write from the aborted command.
    if (!reset_n_i) begin
      cmd_deq_o = 1'b0;
      rsp_enq_o = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      rd_oor_q   <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_oor_q   <= rd_oor_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign rsp_q_o    = rsp_data_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign wr_count_o = wr_cnt_q;
  assign rd_count_o = rd_cnt_q;

endmodule
